// File: rtl/insn_loader_pkg.sv
// Shared types for the instruction loader: FSM state encoding and stream framing sizes.
package insn_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_WORD,
    ST_WRITE,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/insn_loader_if.sv
// Byte-stream input and instruction-memory store port seen by the loader.
// The master side is the loader; the slave side is the host receiver plus the memory.
interface insn_loader_if #(
  parameter int IDX_WIDTH = 9,
  parameter int WIDTH     = 32
);
  logic [7:0]           byte_data;
  logic                 byte_valid;
  logic                 byte_ready;
  logic [IDX_WIDTH+1:0] addr_store;
  logic [WIDTH-1:0]     insn;
  logic                 we;

  modport master (
    input  byte_data, byte_valid,
    output byte_ready, addr_store, insn, we
  );

  modport slave (
    output byte_data, byte_valid,
    input  byte_ready, addr_store, insn, we
  );
endinterface

// File: rtl/insn_byte_packer.sv
// Packs bytes little-endian into a 32-bit word. word_o shows the word including a byte
// being pushed this cycle, so the caller can capture a complete word on the full_o cycle.
module insn_byte_packer
  import insn_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic [7:0]  byte_i,
  input  logic        push_i,
  output logic [31:0] word_o,
  output logic        full_o
);
  localparam int CW = $clog2(WORD_BYTES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   word_q, word_d;

  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clr_i) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (push_i) begin
      word_d[8*cnt_q +: 8] = byte_i;
      cnt_d                = cnt_q + CW'(1);
    end
  end

  assign word_o = word_d;
  assign full_o = push_i && !clr_i && (cnt_q == CW'(WORD_BYTES - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  always_ff @(posedge clk_i) begin
    word_q <= word_d;
  end

endmodule

// File: rtl/insn_loader.sv
// Loads a length-prefixed byte stream into instruction memory and holds the core in reset
// until done. Optional trailing XOR checksum byte enabled by INSN_LOADER_CHECKSUM_EN.
module insn_loader
  import insn_loader_pkg::*;
#(
  parameter int MEM_SIZE  = 512,
  parameter int WIDTH     = 32,
  parameter int IDX_WIDTH = $clog2(MEM_SIZE)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           start_i,
  insn_loader_if.master  bus_if,
  output logic           cpu_hold_o,
  output logic           done_o,
  output logic           err_o
);
`ifdef INSN_LOADER_CHECKSUM_EN
  localparam state_e END_ST = ST_CSUM;
`else
  localparam state_e END_ST = ST_DONE;
`endif

  state_e               state_q;
  logic                 ready_q, we_q, done_q, err_q, hold_q;
  logic [IDX_WIDTH+1:0] addr_q;
  logic [WIDTH-1:0]     insn_q;
  logic [15:0]          len_q;
  logic                 len_cnt_q;
  logic [IDX_WIDTH:0]   widx_q, widx_d;
`ifdef INSN_LOADER_CHECKSUM_EN
  logic [7:0]           csum_q;
`endif

  logic        accept, arm, push, pk_full, last_word;
  logic [31:0] pk_word;
  logic [15:0] len_full;

  assign accept    = ready_q && bus_if.byte_valid;
  assign arm       = start_i && (state_q inside {ST_IDLE, ST_DONE, ST_ERR});
  assign push      = accept && (state_q == ST_WORD);
  assign len_full  = {bus_if.byte_data, len_q[7:0]};
  assign widx_d    = widx_q + (IDX_WIDTH+1)'(1);
  assign last_word = (16'(widx_d) == len_q);

  insn_byte_packer u_packer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (arm),
    .byte_i (bus_if.byte_data),
    .push_i (push),
    .word_o (pk_word),
    .full_o (pk_full)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      hold_q    <= 1'b1;
      addr_q    <= '0;
      insn_q    <= '0;
      len_q     <= '0;
      len_cnt_q <= 1'b0;
      widx_q    <= '0;
`ifdef INSN_LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start_i) begin
            state_q   <= ST_LEN;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            hold_q    <= 1'b1;
            len_cnt_q <= 1'b0;
            widx_q    <= '0;
`ifdef INSN_LOADER_CHECKSUM_EN
            csum_q    <= '0;
`endif
          end
        end
        ST_LEN: begin
          if (accept) begin
`ifdef INSN_LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ bus_if.byte_data;
`endif
            if (len_cnt_q == 1'(LEN_BYTES - 1)) begin
              len_q <= len_full;
              if (len_full > 16'(MEM_SIZE)) begin
                state_q <= ST_ERR;
                ready_q <= 1'b0;
                err_q   <= 1'b1;
              end else if (len_full == 16'd0) begin
                state_q <= END_ST;
                ready_q <= (END_ST == ST_CSUM);
                done_q  <= (END_ST == ST_DONE);
                hold_q  <= (END_ST != ST_DONE);
              end else begin
                state_q <= ST_WORD;
              end
            end else begin
              len_q[7:0] <= bus_if.byte_data;
              len_cnt_q  <= 1'b1;
            end
          end
        end
        ST_WORD: begin
`ifdef INSN_LOADER_CHECKSUM_EN
          if (push) csum_q <= csum_q ^ bus_if.byte_data;
`endif
          if (pk_full) begin
            state_q <= ST_WRITE;
            ready_q <= 1'b0;
            we_q    <= 1'b1;
            insn_q  <= WIDTH'(pk_word);
            addr_q  <= {widx_q[IDX_WIDTH-1:0], 2'b00};
          end
        end
        ST_WRITE: begin
          widx_q <= widx_d;
          if (last_word) begin
            state_q <= END_ST;
            ready_q <= (END_ST == ST_CSUM);
            done_q  <= (END_ST == ST_DONE);
            hold_q  <= (END_ST != ST_DONE);
          end else begin
            state_q <= ST_WORD;
            ready_q <= 1'b1;
          end
        end
`ifdef INSN_LOADER_CHECKSUM_EN
        // The checksum byte itself must be accepted, so ready stays high in this state.
        ST_CSUM: begin
          if (accept) begin
            ready_q <= 1'b0;
            if (bus_if.byte_data == csum_q) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end else begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus_if.byte_ready = ready_q;
  assign bus_if.addr_store = addr_q;
  assign bus_if.insn       = insn_q;
  assign bus_if.we         = we_q;
  assign cpu_hold_o        = hold_q;
  assign done_o            = done_q;
  assign err_o             = err_q;

endmodule

// File: tb/tb_insn_loader.sv
// Scoreboard bench for insn_loader: a stream-level model queues expected memory writes,
// a monitor compares every we pulse. Honours INSN_LOADER_CHECKSUM_EN when defined.
module tb_insn_loader;
  localparam int MEM_SIZE  = 512;
  localparam int IDX_WIDTH = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic hold, done, err;

  insn_loader_if #(.IDX_WIDTH(IDX_WIDTH), .WIDTH(32)) bus ();

  insn_loader #(.MEM_SIZE(MEM_SIZE), .WIDTH(32), .IDX_WIDTH(IDX_WIDTH)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .bus_if     (bus),
    .cpu_hold_o (hold),
    .done_o     (done),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IDX_WIDTH+1:0] a;
    logic [31:0]          d;
  } wr_t;
  typedef logic [7:0] bq_t[$];

  wr_t exp_q[$];
  int  n_chk  = 0;
  int  n_fail = 0;
  int  we_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Monitor: every write strobe must match the head of the expected-write queue.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && bus.we) begin
      we_cnt++;
      check("ready_in_write", 32'(bus.byte_ready), 32'd0);
      if (exp_q.size() == 0) begin
        fail_now($sformatf("unexpected_we addr=0x%0h data=0x%0h", bus.addr_store, bus.insn));
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(bus.addr_store), 32'(e.a));
        check("wr_data", bus.insn, e.d);
      end
    end
  end

`ifdef INSN_LOADER_CHECKSUM_EN
  function automatic logic [7:0] xsum(input bq_t b, input int n);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < n; i++) x ^= b[i];
    return x;
  endfunction
`endif

  // Reference model: length word, then N little-endian words at consecutive word addresses.
  task automatic model(input bq_t b, output bit exp_err);
    int  n;
    wr_t w;
    n = int'({b[1], b[0]});
    exp_err = 1'b0;
    if (n > MEM_SIZE) begin
      exp_err = 1'b1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      w.a = (IDX_WIDTH+2)'(4 * i);
      w.d = {b[2+4*i+3], b[2+4*i+2], b[2+4*i+1], b[2+4*i]};
      exp_q.push_back(w);
    end
`ifdef INSN_LOADER_CHECKSUM_EN
    exp_err = (b[2+4*n] != xsum(b, 2 + 4 * n));
`endif
  endtask

  function automatic bq_t mk_load(input int n);
    bq_t q;
    q.push_back(8'(n));
    q.push_back(8'(n >> 8));
    for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
`ifdef INSN_LOADER_CHECKSUM_EN
    q.push_back(xsum(q, q.size()));
`endif
    return q;
  endfunction

  // All drive tasks start and end on a falling edge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard = 0;
    repeat (gap) @(negedge clk);
    bus.byte_data  = b;
    bus.byte_valid = 1'b1;
    while (!bus.byte_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      fail_now("ready_timeout");
      bus.byte_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic wait_end();
    int k = 0;
    while (!(done || err) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) fail_now("end_timeout");
  endtask

  task automatic run_load(input bq_t b, input int gap, input bit fixed, input string tag);
    bit ee;
    model(b, ee);
    pulse_start();
    foreach (b[i]) send_byte(b[i], fixed ? gap : int'($urandom_range(0, gap)));
    wait_end();
    check({tag, "_done"}, 32'(done), 32'(!ee));
    check({tag, "_err"}, 32'(err), 32'(ee));
    check({tag, "_hold"}, 32'(hold), 32'(ee));
    check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bq_t b;
    bit  ee;
    int  we0;

    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_hold", 32'(hold), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready", 32'(bus.byte_ready), 32'd0);
    check("rst_we", 32'(bus.we), 32'd0);
    check("rst_addr", 32'(bus.addr_store), 32'd0);
    check("rst_insn", bus.insn, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed two-word program with exact latency checks.
    b = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef INSN_LOADER_CHECKSUM_EN
    b.push_back(xsum(b, b.size()));
`endif
    model(b, ee);
    pulse_start();
    for (int i = 0; i < b.size(); i++) begin
      send_byte(b[i], 0);
      if (i == 5 || i == 9) check("we_latency", 32'(bus.we), 32'd1);
    end
`ifdef INSN_LOADER_CHECKSUM_EN
    wait_end();
`else
    @(negedge clk);
`endif
    check("t1_done", 32'(done), 32'd1);
    check("t1_hold", 32'(hold), 32'd0);
    check("t1_writes_left", 32'(exp_q.size()), 32'd0);

    // Full memory, then one word too many.
    we0 = we_cnt;
    run_load(mk_load(MEM_SIZE), 0, 1'b1, "n512");
    check("n512_pulses", 32'(we_cnt - we0), 32'd512);
    check("n512_last_addr", 32'(bus.addr_store), 32'h7FC);
    we0 = we_cnt;
    b = '{8'h01, 8'h02};
    run_load(b, 0, 1'b1, "n513");
    repeat (5) @(negedge clk);
    check("n513_pulses", 32'(we_cnt - we0), 32'd0);
    check("n513_err_sticky", 32'(err), 32'd1);
    check("n513_ready", 32'(bus.byte_ready), 32'd0);

    // Valid dropped for two cycles before every byte.
    run_load(mk_load(1), 2, 1'b1, "gaps");

    // Reset in the middle of a word.
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_hold", 32'(hold), 32'd1);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_ready", 32'(bus.byte_ready), 32'd0);
    check("midrst_we", 32'(bus.we), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_load(mk_load(3), 1, 1'b0, "after_rst");

    // Empty program.
    we0 = we_cnt;
    b = '{8'h00, 8'h00};
`ifdef INSN_LOADER_CHECKSUM_EN
    b.push_back(8'h00);
`endif
    run_load(b, 0, 1'b1, "n0");
    check("n0_pulses", 32'(we_cnt - we0), 32'd0);

    // start_i mid-word must not disturb the partial word or the counters.
    b = mk_load(2);
    model(b, ee);
    pulse_start();
    for (int i = 0; i < b.size(); i++) begin
      send_byte(b[i], 0);
      if (i == 3) pulse_start();
    end
    wait_end();
    check("ign_start_done", 32'(done), 32'(!ee));
    check("ign_start_writes_left", 32'(exp_q.size()), 32'd0);

`ifdef INSN_LOADER_CHECKSUM_EN
    b = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
    run_load(b, 0, 1'b1, "csum_ok");
    check("csum_ok_fixed", 32'(done), 32'd1);
    b = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    run_load(b, 0, 1'b1, "csum_bad");
    check("csum_bad_fixed_err", 32'(err), 32'd1);
    check("csum_bad_fixed_hold", 32'(hold), 32'd1);
`endif

    // Random programs with random valid gaps.
    for (int t = 0; t < 8; t++) begin
      b = mk_load(int'($urandom_range(1, 6)));
`ifdef INSN_LOADER_CHECKSUM_EN
      if ($urandom_range(0, 1) == 1) b[b.size()-1] = b[b.size()-1] ^ 8'h5A;
`endif
      run_load(b, 3, 1'b0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
